// File: rtl/touch_report_avalon.sv
// Purpose: Avalon-MM register slave exposing touch-controller frame snapshots, counters and an interrupt.
// Latency: readdata is registered and valid one cycle after read is sampled; irq lags new_frame by one cycle.
// Backpressure: none; the slave always accepts reads and writes, and frames arriving while frozen are counted and flagged as overrun.
//
// Ports: i_clock/i_reset (sync, active-high), Avalon slave (i_address, i_read, i_write, i_writedata,
//        o_readdata), o_irq level interrupt, frame input (i_frame_valid, i_touch_count, i_gesture,
//        i_points_x, i_points_y with point i at slice [i*W +: W]).
// Optional feature: define TOUCH_GESTURE_FIFO_EN to queue nonzero gestures in a 4-entry FIFO that is
//        popped by GESTURE reads; otherwise GESTURE holds the gesture captured with the last snapshot.
module touch_report_avalon #(
    parameter int NUM_POINTS = 5,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int ADDR_W     = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [ADDR_W-1:0]         i_address,
    input  logic                      i_read,
    input  logic                      i_write,
    input  logic [31:0]               i_writedata,
    output logic [31:0]               o_readdata,
    output logic                      o_irq,
    input  logic                      i_frame_valid,
    input  logic [3:0]                i_touch_count,
    input  logic [7:0]                i_gesture,
    input  logic [NUM_POINTS*X_W-1:0] i_points_x,
    input  logic [NUM_POINTS*Y_W-1:0] i_points_y
);

    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CONTROL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_COUNT   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_GESTURE = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_FRAMES  = ADDR_W'(4);

    logic [1:0]     r_ctrl;          // [0] irq_en, [1] freeze
    logic           r_new_frame;
    logic           r_overrun;
    logic [3:0]     r_count;
    logic [X_W-1:0] r_px [NUM_POINTS];
    logic [Y_W-1:0] r_py [NUM_POINTS];
    logic [15:0]    r_frames;
    logic           r_irq;
    logic [31:0]    r_readdata;

    logic        w_wr_status;
    logic        w_wr_ctrl;
    logic        w_capture;
    logic [3:0]  w_count_clamped;
    logic [31:0] w_rdata;
    logic [31:0] w_gesture_rd;
    logic        w_gest_avail;
    logic        w_gest_ovf;
    logic        w_unused_ok;

    assign w_wr_status     = i_write && (i_address == A_STATUS);
    assign w_wr_ctrl       = i_write && (i_address == A_CONTROL);
    assign w_capture       = i_frame_valid && !r_ctrl[1];
    assign w_count_clamped = (i_touch_count > 4'(NUM_POINTS)) ? 4'(NUM_POINTS) : i_touch_count;

`ifdef TOUCH_GESTURE_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_fcnt;
    logic       r_gest_ovf;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push_req;
    logic       w_push;
    logic       w_ovf_evt;

    assign w_empty    = (r_fcnt == 3'd0);
    assign w_full     = (r_fcnt == 3'd4);
    assign w_pop      = i_read && (i_address == A_GESTURE) && !w_empty;
    assign w_push_req = i_frame_valid && (i_gesture != 8'd0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt  = w_push_req && w_full && !w_pop;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fcnt     <= '0;
            r_gest_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= i_gesture;
                r_wptr         <= r_wptr + 2'd1;
            end
            if (w_pop) r_rptr <= r_rptr + 2'd1;
            r_fcnt     <= r_fcnt + {2'b0, w_push} - {2'b0, w_pop};
            // Set wins over the W1C clear.
            r_gest_ovf <= (r_gest_ovf && !(w_wr_status && i_writedata[4])) || w_ovf_evt;
        end
    end

    assign w_gesture_rd = w_empty ? 32'd0 : {23'd0, 1'b1, r_fifo[r_rptr]};
    assign w_gest_avail = !w_empty;
    assign w_gest_ovf   = r_gest_ovf;
    assign w_unused_ok  = &{1'b0, i_writedata[31:5], i_writedata[3:2]};
`else
    logic [7:0] r_gesture;

    always_ff @(posedge i_clock) begin
        if (i_reset)        r_gesture <= '0;
        else if (w_capture) r_gesture <= i_gesture;
    end

    assign w_gesture_rd = {24'd0, r_gesture};
    assign w_gest_avail = 1'b0;
    assign w_gest_ovf   = 1'b0;
    assign w_unused_ok  = &{1'b0, i_writedata[31:4], i_writedata[3:2]};
`endif

    always_comb begin
        w_rdata = 32'd0;
        case (i_address)
            A_STATUS:  w_rdata = {27'd0, w_gest_ovf, w_gest_avail, r_ctrl[1], r_overrun, r_new_frame};
            A_CONTROL: w_rdata = {30'd0, r_ctrl};
            A_COUNT:   w_rdata = {28'd0, r_count};
            A_GESTURE: w_rdata = w_gesture_rd;
            A_FRAMES:  w_rdata = {16'd0, r_frames};
            default:   w_rdata = 32'd0;
        endcase
        for (int i = 0; i < NUM_POINTS; i++) begin
            if (i_address == ADDR_W'(i + 5))
                w_rdata = (32'(r_py[i]) << X_W) | 32'(r_px[i]);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ctrl      <= '0;
            r_new_frame <= 1'b0;
            r_overrun   <= 1'b0;
            r_count     <= '0;
            for (int i = 0; i < NUM_POINTS; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
            r_frames    <= '0;
            r_irq       <= 1'b0;
            r_readdata  <= '0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= i_writedata[1:0];
            // Sticky bits: a frame event in the same cycle overrides the W1C clear.
            r_new_frame <= (r_new_frame && !(w_wr_status && i_writedata[0])) || w_capture;
            r_overrun   <= (r_overrun && !(w_wr_status && i_writedata[1])) ||
                           (i_frame_valid && r_ctrl[1]);
            if (i_frame_valid) r_frames <= r_frames + 16'd1;
            if (w_capture) begin
                r_count <= w_count_clamped;
                for (int i = 0; i < NUM_POINTS; i++) begin
                    r_px[i] <= i_points_x[i*X_W +: X_W];
                    r_py[i] <= i_points_y[i*Y_W +: Y_W];
                end
            end
            r_irq <= r_ctrl[0] && r_new_frame;
            if (i_read) r_readdata <= w_rdata;
        end
    end

    assign o_readdata = r_readdata;
    assign o_irq      = r_irq;

endmodule

// File: tb/tb_touch_report_avalon.sv
module tb_touch_report_avalon;

    localparam int NP  = 5;
    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int AW  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic              rd = 1'b0;
    logic              wr = 1'b0;
    logic [31:0]       wdata = '0;
    logic [31:0]       o_readdata;
    logic              o_irq;
    logic              fv = 1'b0;
    logic [3:0]        tcount = '0;
    logic [7:0]        gest = '0;
    logic [X_W-1:0]    px_in [NP];
    logic [Y_W-1:0]    py_in [NP];
    logic [NP*X_W-1:0] points_x;
    logic [NP*Y_W-1:0] points_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        points_x = '0;
        points_y = '0;
        for (int i = 0; i < NP; i++) begin
            points_x[i*X_W +: X_W] = px_in[i];
            points_y[i*Y_W +: Y_W] = py_in[i];
        end
    end

    touch_report_avalon #(.NUM_POINTS(NP), .X_W(X_W), .Y_W(Y_W), .ADDR_W(AW)) dut (
        .i_clock(clk), .i_reset(rst), .i_address(addr), .i_read(rd), .i_write(wr),
        .i_writedata(wdata), .o_readdata(o_readdata), .o_irq(o_irq),
        .i_frame_valid(fv), .i_touch_count(tcount), .i_gesture(gest),
        .i_points_x(points_x), .i_points_y(points_y)
    );

    // Reference model: register-map state as the host sees it.
    bit [1:0]    m_ctrl;
    bit          m_new, m_ovr, m_gov, m_irq;
    int          m_count, m_frames, m_gest;
    int          m_px [NP];
    int          m_py [NP];
    int          m_q [$];
    logic [31:0] m_rdata;

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] r;
        r = 32'd0;
        if (a == 0) r = {27'd0, m_gov, (m_q.size() > 0), m_ctrl[1], m_ovr, m_new};
        else if (a == 1) r = {30'd0, m_ctrl};
        else if (a == 2) r = 32'(m_count);
        else if (a == 3) begin
`ifdef TOUCH_GESTURE_FIFO_EN
            r = (m_q.size() > 0) ? (32'h100 | 32'(m_q[0])) : 32'd0;
`else
            r = 32'(m_gest);
`endif
        end
        else if (a == 4) r = 32'(m_frames);
        else if (a >= 5 && a < 5 + NP) r = (32'(m_py[a-5]) << X_W) | 32'(m_px[a-5]);
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        bit [1:0] oc;
        bit       on;
        oc = m_ctrl;
        on = m_new;
        if (rst) begin
            m_ctrl = 0; m_new = 0; m_ovr = 0; m_gov = 0; m_irq = 0;
            m_count = 0; m_frames = 0; m_gest = 0; m_rdata = 0;
            for (int i = 0; i < NP; i++) begin m_px[i] = 0; m_py[i] = 0; end
            m_q.delete();
        end else begin
            if (rd) m_rdata = m_read(int'(addr));
`ifdef TOUCH_GESTURE_FIFO_EN
            if (rd && addr == 4'd3 && m_q.size() > 0) void'(m_q.pop_front());
`endif
            if (wr && addr == 4'd0) begin
                if (wdata[0]) m_new = 0;
                if (wdata[1]) m_ovr = 0;
                if (wdata[4]) m_gov = 0;
            end
            if (wr && addr == 4'd1) m_ctrl = wdata[1:0];
            if (fv) begin
                m_frames = (m_frames + 1) % 65536;
                if (!oc[1]) begin
                    m_new = 1;
                    m_count = (int'(tcount) > NP) ? NP : int'(tcount);
                    for (int i = 0; i < NP; i++) begin m_px[i] = int'(px_in[i]); m_py[i] = int'(py_in[i]); end
                    m_gest = int'(gest);
                end else m_ovr = 1;
`ifdef TOUCH_GESTURE_FIFO_EN
                if (gest != 8'd0) begin
                    if (m_q.size() < 4) m_q.push_back(int'(gest));
                    else m_gov = 1;
                end
`endif
            end
            m_irq = oc[0] && on;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int a, output logic [31:0] got);
        addr = AW'(a); rd = 1'b1; tick(); rd = 1'b0; got = o_readdata;
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        addr = AW'(a); wdata = d; wr = 1'b1; tick(); wr = 1'b0;
    endtask

    task automatic do_frame(input int cnt, input int g);
        fv = 1'b1; tcount = 4'(cnt); gest = 8'(g); tick(); fv = 1'b0; gest = 8'd0;
    endtask

    task automatic rand_points();
        for (int i = 0; i < NP; i++) begin
            px_in[i] = X_W'($urandom);
            py_in[i] = Y_W'($urandom);
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        rst = 1'b1; rd = 1'b1; fv = 1'b1; wr = 1'b1; addr = 4'd1; wdata = 32'h3;
        tick();
        rst = 1'b0; rd = 1'b0; fv = 1'b0; wr = 1'b0;
        checks++;
        if (o_readdata !== 32'd0 || o_irq !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: readdata=%h irq=%b required 0/0", o_readdata, o_irq);
        end
        for (int a = 0; a < 16; a++) begin
            do_read(a, got);
            checks++;
            if (got !== 32'd0) begin
                errors++; $display("FAIL reset_reg[%0d]: got %h required 0", a, got);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] got;
        rand_points();
        px_in[0] = 10'd100; py_in[0] = 9'd50;
        do_frame(2, 0);
        do_read(2, got); checks++;
        if (got !== 32'd2) begin errors++; $display("FAIL basic_count: got %h required 2", got); end
        do_read(5, got); checks++;
        if (got !== 32'h0000C864) begin errors++; $display("FAIL basic_point0: got %h required 0000c864", got); end
        do_read(6, got); checks++;
        if (got !== m_rdata) begin errors++; $display("FAIL basic_point1: got %h required %h", got, m_rdata); end
        do_read(0, got); checks++;
        if (got[0] !== 1'b1) begin errors++; $display("FAIL basic_new_frame: got %b required 1", got[0]); end
        do_read(4, got); checks++;
        if (got !== 32'd1) begin errors++; $display("FAIL basic_frames: got %h required 1", got); end
    endtask

    task automatic test_irq();
        logic [31:0] got;
        do_write(0, 32'h13);
        do_write(1, 32'h1);
        tick();
        checks++;
        if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b required 0", o_irq); end
        do_frame(1, 0);
        tick();
        checks++;
        if (o_irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b required 1", o_irq); end
        do_write(0, 32'h1);
        tick();
        checks++;
        if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", o_irq); end
        fv = 1'b1; tcount = 4'd1; wr = 1'b1; addr = 4'd0; wdata = 32'h1;
        tick();
        fv = 1'b0; wr = 1'b0;
        do_read(0, got); checks++;
        if (got[0] !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b required 1", got[0]); end
        do_write(1, 32'h0);
    endtask

    task automatic test_freeze();
        logic [31:0] got;
        logic [31:0] old_p0;
        int          f0;
        do_write(0, 32'h13);
        do_write(1, 32'h2);
        old_p0 = (32'(m_py[0]) << X_W) | 32'(m_px[0]);
        f0 = m_frames;
        rand_points();
        do_frame(3, 0);
        for (int i = 0; i < NP; i++) begin
            do_read(5 + i, got); checks++;
            if (got !== m_rdata || (i == 0 && got !== old_p0)) begin
                errors++; $display("FAIL freeze_point[%0d]: got %h required %h", i, got, m_rdata);
            end
        end
        do_read(0, got); checks++;
        if (got !== 32'h6) begin errors++; $display("FAIL freeze_status: got %h required 6", got); end
        do_read(4, got); checks++;
        if (got !== 32'(f0 + 1)) begin errors++; $display("FAIL freeze_frames: got %h required %h", got, f0 + 1); end
        do_write(1, 32'h0);
        px_in[0] = 10'h3A5; py_in[0] = 9'h15A;
        do_frame(4, 0);
        do_read(5, got); checks++;
        if (got !== ((32'h15A << X_W) | 32'h3A5)) begin errors++; $display("FAIL unfreeze_point0: got %h required %h", got, (32'h15A << X_W) | 32'h3A5); end
        do_read(2, got); checks++;
        if (got !== 32'd4) begin errors++; $display("FAIL unfreeze_count: got %h required 4", got); end
    endtask

    task automatic test_clamp();
        logic [31:0] got;
        do_frame(9, 0);
        do_read(2, got); checks++;
        if (got !== 32'(NP)) begin errors++; $display("FAIL clamp_count: got %h required %h", got, NP); end
        do_write(2, 32'hFFFF_FFFF);
        do_write(4, 32'hFFFF_FFFF);
        do_write(13, 32'hFFFF_FFFF);
        do_read(2, got); checks++;
        if (got !== 32'(NP)) begin errors++; $display("FAIL ro_count_write: got %h required %h", got, NP); end
        do_read(4, got); checks++;
        if (got !== m_rdata) begin errors++; $display("FAIL ro_frames_write: got %h required %h", got, m_rdata); end
        do_read(13, got); checks++;
        if (got !== 32'd0) begin errors++; $display("FAIL unmapped_13: got %h required 0", got); end
    endtask

    task automatic test_gesture();
        logic [31:0] got;
        rst = 1'b1; tick(); rst = 1'b0;
`ifdef TOUCH_GESTURE_FIFO_EN
        for (int k = 0; k < 5; k++) do_frame(1, 16 + k);
        do_read(0, got); checks++;
        if (got[4:3] !== 2'b11) begin errors++; $display("FAIL fifo_ovf_status: got %b required 11", got[4:3]); end
        for (int k = 0; k < 5; k++) begin
            do_read(3, got); checks++;
            if (got !== ((k < 4) ? 32'(32'h110 + k) : 32'd0)) begin
                errors++; $display("FAIL fifo_pop[%0d]: got %h required %h", k, got, (k < 4) ? 32'(32'h110 + k) : 32'd0);
            end
        end
        do_write(0, 32'h10);
        for (int k = 0; k < 4; k++) do_frame(1, 32 + k);
        fv = 1'b1; gest = 8'h77; rd = 1'b1; addr = 4'd3;
        tick();
        fv = 1'b0; gest = 8'd0; rd = 1'b0;
        checks++;
        if (o_readdata !== 32'h120) begin errors++; $display("FAIL fifo_pushpop_full: got %h required 120", o_readdata); end
        do_read(0, got); checks++;
        if (got[4:3] !== 2'b01) begin errors++; $display("FAIL fifo_no_ovf: got %b required 01", got[4:3]); end
        for (int k = 0; k < 4; k++) begin
            do_read(3, got); checks++;
            if (got !== ((k < 3) ? 32'(32'h121 + k) : 32'h177)) begin
                errors++; $display("FAIL fifo_drain[%0d]: got %h required %h", k, got, (k < 3) ? 32'(32'h121 + k) : 32'h177);
            end
        end
`else
        do_frame(1, 8'h2A);
        do_read(3, got); checks++;
        if (got !== 32'h2A) begin errors++; $display("FAIL gesture_capture: got %h required 2a", got); end
        do_write(1, 32'h2);
        do_frame(1, 8'h55);
        do_read(3, got); checks++;
        if (got !== 32'h2A) begin errors++; $display("FAIL gesture_frozen: got %h required 2a", got); end
        do_read(0, got); checks++;
        if (got[4:3] !== 2'b00) begin errors++; $display("FAIL gesture_status_bits: got %b required 00", got[4:3]); end
        do_write(1, 32'h0);
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rd = 1'($urandom);
            wr = ($urandom % 4) == 0;
            addr = AW'($urandom);
            wdata = $urandom;
            fv = ($urandom % 3) == 0;
            tcount = 4'($urandom);
            gest = (($urandom % 2) == 0) ? 8'd0 : 8'($urandom);
            rand_points();
            tick();
            checks++;
            if (o_readdata !== m_rdata || o_irq !== m_irq) begin
                errors++;
                $display("FAIL random[%0d]: readdata=%h irq=%b required %h/%b", c, o_readdata, o_irq, m_rdata, m_irq);
            end
        end
        rd = 1'b0; wr = 1'b0; fv = 1'b0; gest = 8'd0;
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] got;
        rst = 1'b1; tick(); rst = 1'b0;
        fv = 1'b1; tcount = 4'd3;
        for (int k = 0; k < 65535; k++) tick();
        fv = 1'b0;
        do_read(4, got); checks++;
        if (got !== 32'hFFFF) begin errors++; $display("FAIL frames_max: got %h required ffff", got); end
        do_frame(2, 0);
        do_read(4, got); checks++;
        if (got !== 32'd0) begin errors++; $display("FAIL frames_wrap: got %h required 0", got); end
        do_write(1, 32'h3);
        do_frame(2, 8'h42);
        tick();
        rst = 1'b1; rd = 1'b1; addr = 4'd4; fv = 1'b1; wr = 1'b1; wdata = 32'h3;
        tick();
        rst = 1'b0; rd = 1'b0; fv = 1'b0; wr = 1'b0;
        checks++;
        if (o_readdata !== 32'd0 || o_irq !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: readdata=%h irq=%b required 0/0", o_readdata, o_irq);
        end
        for (int a = 0; a < 5 + NP; a++) begin
            do_read(a, got); checks++;
            if (got !== 32'd0) begin errors++; $display("FAIL midreset_reg[%0d]: got %h required 0", a, got); end
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin px_in[i] = '0; py_in[i] = '0; end
        tick();
        test_reset();
        test_basic();
        test_irq();
        test_freeze();
        test_clamp();
        test_gesture();
        test_random();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
